echo_indication_deserializer: RTL and testbench

//   Receive end of the echo indication link: reassembles 32-bit beats from the

---
 rtl/echo_indication_deserializer_if.sv | 29 ++
 rtl/echo_indication_deserializer.sv | 100 ++++++++++
 tb/tb_echo_indication_deserializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/echo_indication_deserializer_if.sv
`default_nettype none
// ============================================================================
// echo_indication_deserializer_if : transport beat input and heard() output
// Rev 1.0 : initial release
// ============================================================================
interface echo_indication_deserializer_if #(
  parameter int CNT_W = 16
);
  logic             enq__ENA;
  logic [31:0]      enq_v;
  logic             enq__RDY;
  logic             heard__ENA;
  logic [31:0]      heard_meth;
  logic [31:0]      heard_v;
  logic             heard__RDY;
  logic [CNT_W-1:0] drop_count;

  // master: transport source plus host consumer; slave: the deserializer
  modport master (
    output enq__ENA, enq_v, heard__RDY,
    input  enq__RDY, heard__ENA, heard_meth, heard_v, drop_count
  );

  modport slave (
    input  enq__ENA, enq_v, heard__RDY,
    output enq__RDY, heard__ENA, heard_meth, heard_v, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/echo_indication_deserializer.sv
`default_nettype none
// ============================================================================
// echo_indication_deserializer : reassembles header/meth/v beats into heard()
// Rev 1.0 : initial release
// ============================================================================
module echo_indication_deserializer #(
  parameter logic [15:0] HEARD_ID  = 16'h0001,
  parameter logic [15:0] MSG_BEATS = 16'd3,
  parameter int          CNT_W     = 16
) (
  input  wire                                  CLK,
  input  wire                                  nRST,
  echo_indication_deserializer_if.slave        bus
);

  typedef enum logic [2:0] {
    S_HDR      = 3'd0,
    S_ARG0     = 3'd1,
    S_ARG1     = 3'd2,
    S_DISPATCH = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t           state_q;
  logic [31:0]      meth_q;
  logic [31:0]      v_q;
  logic [15:0]      rem_q;
  logic [CNT_W-1:0] drop_q;

  logic             w_enq_fire;
  logic             w_heard_fire;
  logic [15:0]      w_id;
  logic [15:0]      w_len;
  logic             w_drop_sat;

  assign w_id         = bus.enq_v[31:16];
  assign w_len        = bus.enq_v[15:0];
  assign w_enq_fire   = bus.enq__ENA && (state_q != S_DISPATCH);
  assign w_heard_fire = (state_q == S_DISPATCH) && bus.heard__RDY;
  assign w_drop_sat   = (drop_q == {CNT_W{1'b1}});

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_HDR;
      meth_q  <= 32'd0;
      v_q     <= 32'd0;
      rem_q   <= 16'd0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (w_enq_fire) begin
            if (w_id == HEARD_ID && w_len == MSG_BEATS) begin
              state_q <= S_ARG0;
            end else if (w_len <= 16'd1) begin
              // header-only junk: nothing to drain, count it now
              if (!w_drop_sat) drop_q <= drop_q + CNT_W'(1);
            end else begin
              rem_q   <= w_len - 16'd1;
              state_q <= S_DRAIN;
            end
          end
        end
        S_ARG0: begin
          if (w_enq_fire) begin
            meth_q  <= bus.enq_v;
            state_q <= S_ARG1;
          end
        end
        S_ARG1: begin
          if (w_enq_fire) begin
            v_q     <= bus.enq_v;
            state_q <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (w_heard_fire) state_q <= S_HDR;
        end
        S_DRAIN: begin
          if (w_enq_fire) begin
            if (rem_q == 16'd1) begin
              state_q <= S_HDR;
              if (!w_drop_sat) drop_q <= drop_q + CNT_W'(1);
            end
            rem_q <= rem_q - 16'd1;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign bus.enq__RDY   = (state_q != S_DISPATCH);
  assign bus.heard__ENA = w_heard_fire;
  assign bus.heard_meth = meth_q;
  assign bus.heard_v    = v_q;
  assign bus.drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_deserializer.sv
`default_nettype none
// ============================================================================
// tb_echo_indication_deserializer : directed self-checking bench
// Rev 1.0 : initial release
// ============================================================================
module tb_echo_indication_deserializer;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] fire_meth[$];
  logic [31:0] fire_v[$];
  int          fire_cyc[$];

  echo_indication_deserializer_if #(.CNT_W(16)) bus ();

  echo_indication_deserializer #(
    .HEARD_ID  (16'h0001),
    .MSG_BEATS (16'd3),
    .CNT_W     (16)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // records every heard fire with the cycle it happened in
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (nRST && bus.heard__ENA) begin
      fire_meth.push_back(bus.heard_meth);
      fire_v.push_back(bus.heard_v);
      fire_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] v);
    bus.enq__ENA = 1'b1;
    bus.enq_v    = v;
    step();
    bus.enq__ENA = 1'b0;
  endtask

  logic [31:0] b2b[9];
  int          base;
  int          idx;
  int          budget;
  logic        acc;

  initial begin
    bus.enq__ENA   = 1'b0;
    bus.enq_v      = 32'd0;
    bus.heard__RDY = 1'b0;

    // reset state
    step(); step();
    chk("rst_enq_rdy",  {31'd0, bus.enq__RDY},   32'd1);
    chk("rst_heard_ena",{31'd0, bus.heard__ENA}, 32'd0);
    chk("rst_meth",     bus.heard_meth,          32'd0);
    chk("rst_v",        bus.heard_v,             32'd0);
    chk("rst_drop",     {16'd0, bus.drop_count}, 32'd0);
    nRST = 1'b1;
    step();
    chk("post_rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);

    // 1: basic dispatch
    bus.heard__RDY = 1'b1;
    send_beat(32'h0001_0003);
    send_beat(32'h0000_0011);
    chk("t1_no_early_fire", {31'd0, bus.heard__ENA}, 32'd0);
    send_beat(32'h0000_0022);
    chk("t1_heard_ena", {31'd0, bus.heard__ENA}, 32'd1);
    chk("t1_enq_rdy_lo",{31'd0, bus.enq__RDY},   32'd0);
    chk("t1_meth",      bus.heard_meth,          32'h11);
    chk("t1_v",         bus.heard_v,             32'h22);
    step();
    chk("t1_heard_done",{31'd0, bus.heard__ENA}, 32'd0);
    chk("t1_enq_rdy_hi",{31'd0, bus.enq__RDY},   32'd1);
    chk("t1_fires",     fire_meth.size(),        32'd1);
    chk("t1_drop",      {16'd0, bus.drop_count}, 32'd0);

    // 2: back-pressure from consumer; beats offered while stalled are ignored
    bus.heard__RDY = 1'b0;
    send_beat(32'h0001_0003);
    send_beat(32'h0000_0033);
    send_beat(32'h0000_0044);
    for (int i = 0; i < 5; i++) begin
      bus.enq__ENA = 1'b1;
      bus.enq_v    = 32'h0009_0001;
      chk("t2_stall_ena", {31'd0, bus.heard__ENA}, 32'd0);
      chk("t2_stall_rdy", {31'd0, bus.enq__RDY},   32'd0);
      chk("t2_stall_meth", bus.heard_meth,         32'h33);
      chk("t2_stall_v",    bus.heard_v,            32'h44);
      step();
    end
    bus.enq__ENA   = 1'b0;
    bus.heard__RDY = 1'b1;
    #1;
    chk("t2_fire_ena", {31'd0, bus.heard__ENA}, 32'd1);
    step();
    chk("t2_enq_rdy_after", {31'd0, bus.enq__RDY}, 32'd1);
    chk("t2_fires",  fire_meth.size(), 32'd2);
    chk("t2_meth",   fire_meth[1],     32'h33);
    chk("t2_drop_ignored", {16'd0, bus.drop_count}, 32'd0);

    // 3: unknown id with payload drained, then valid message
    send_beat(32'h0007_0004);
    send_beat(32'h0000_00A1);
    send_beat(32'h0000_00A2);
    chk("t3_drop_mid", {16'd0, bus.drop_count}, 32'd0);
    send_beat(32'h0000_00A3);
    chk("t3_drop", {16'd0, bus.drop_count}, 32'd1);
    chk("t3_no_fire", fire_meth.size(), 32'd2);
    send_beat(32'h0001_0003);
    send_beat(32'h0000_0055);
    send_beat(32'h0000_0066);
    chk("t3_heard_ena", {31'd0, bus.heard__ENA}, 32'd1);
    step();
    chk("t3_fires", fire_meth.size(), 32'd3);
    chk("t3_meth",  fire_meth[2],     32'h55);
    chk("t3_v",     fire_v[2],        32'h66);

    // 4: right id, wrong length drained; header-only junk counted at once
    send_beat(32'h0001_0005);
    send_beat(32'h0000_00B1);
    send_beat(32'h0000_00B2);
    send_beat(32'h0000_00B3);
    chk("t4_drop_mid", {16'd0, bus.drop_count}, 32'd1);
    send_beat(32'h0000_00B4);
    chk("t4_drop_drain", {16'd0, bus.drop_count}, 32'd2);
    send_beat(32'h0009_0001);
    chk("t4_drop_hdr_only", {16'd0, bus.drop_count}, 32'd3);
    chk("t4_rdy", {31'd0, bus.enq__RDY}, 32'd1);
    chk("t4_no_fire", fire_meth.size(), 32'd3);

    // 5: asynchronous reset mid-message
    send_beat(32'h0001_0003);
    send_beat(32'h0000_DEAD);
    #2 nRST = 1'b0;
    #1;
    chk("t5_rst_drop", {16'd0, bus.drop_count}, 32'd0);
    chk("t5_rst_meth", bus.heard_meth, 32'd0);
    chk("t5_rst_rdy",  {31'd0, bus.enq__RDY}, 32'd1);
    step();
    nRST = 1'b1;
    step();
    send_beat(32'h0001_0003);
    send_beat(32'h0000_0077);
    send_beat(32'h0000_0088);
    chk("t5_meth_live", bus.heard_meth, 32'h77);
    step();
    chk("t5_fires", fire_meth.size(), 32'd4);
    chk("t5_meth",  fire_meth[3],     32'h77);
    chk("t5_v",     fire_v[3],        32'h88);
    chk("t5_drop",  {16'd0, bus.drop_count}, 32'd0);

    // 6: back-to-back messages, source and sink always ready
    b2b = '{32'h0001_0003, 32'h0000_0101, 32'h0000_0201,
            32'h0001_0003, 32'h0000_0102, 32'h0000_0202,
            32'h0001_0003, 32'h0000_0103, 32'h0000_0203};
    base   = fire_meth.size();
    idx    = 0;
    budget = 0;
    bus.enq__ENA = 1'b1;
    while (idx < 9 && budget < 40) begin
      bus.enq_v = b2b[idx];
      acc = bus.enq__RDY;
      step();
      if (acc) idx++;
      budget++;
    end
    bus.enq__ENA = 1'b0;
    chk("t6_all_beats_taken", idx, 32'd9);
    step(); step();
    chk("t6_fires", fire_meth.size() - base, 32'd3);
    if (fire_meth.size() - base == 3) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("t6_meth%0d", m), fire_meth[base+m], 32'h0000_0101 + m);
        chk($sformatf("t6_v%0d", m),    fire_v[base+m],    32'h0000_0201 + m);
      end
      chk("t6_gap01", fire_cyc[base+1] - fire_cyc[base],   32'd4);
      chk("t6_gap12", fire_cyc[base+2] - fire_cyc[base+1], 32'd4);
    end
    chk("t6_drop", {16'd0, bus.drop_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
